// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with redirect, drain and decode handshake
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] pc_plus4
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] redirect_tgt;

  // Branch targets are forced word-aligned on every load into pc.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Sequencing of the fetch: issue, present to decode, and flush on redirect.
  // While draining, the outstanding request keeps its old address in
  // drain_addr so pc can already track the newest redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
      if_pc      <= 32'h0;
      if_instr   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= redirect_tgt;
          state <= REQ;
        end
        REQ: begin
          if (redirect) begin
            pc <= redirect_tgt;
            if (!imem_ack) begin
              drain_addr <= pc;
              state      <= DRAIN;
            end
          end else if (imem_ack) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= redirect_tgt;
            state <= REQ;
          end else if (if_ready) begin
            pc    <= pc + 32'd4;
            state <= REQ;
          end
        end
        DRAIN: begin
          if (redirect) pc <= redirect_tgt;
          if (imem_ack) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from state so reset takes effect without a clock.
  always_comb begin
    imem_req  = (state == REQ) || (state == DRAIN);
    imem_addr = (state == DRAIN) ? drain_addr : pc;
    if_valid  = (state == HOLD);
    pc_plus4  = if_pc + 32'd4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc_plus4;

  fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    int          ack_lat;
    int          rdy_lat;
  } fvec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int start_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00000013 ^ (a << 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    check("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic reset_values();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
  endtask

  // One complete fetch: request at exp_addr, ack after ack_lat, accept after rdy_lat.
  task automatic fetch_one(input logic [31:0] exp_addr, input int ack_lat, input int rdy_lat);
    exp_t e;
    logic [31:0] held_pc, held_instr;
    wait_req();
    start_cyc = cyc;
    check("req_addr", imem_addr, exp_addr);
    for (int k = 0; k < ack_lat; k++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("addr_stable", imem_addr, exp_addr);
      check("req_held", {31'b0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(exp_addr);
    sb.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
    @(negedge clk);
    imem_ack = 1'b0;
    check("valid_after_ack", {31'b0, if_valid}, 32'd1);
    held_pc    = if_pc;
    held_instr = if_instr;
    for (int k = 0; k < rdy_lat; k++) begin
      if_ready = 1'b0;
      @(negedge clk);
      check("stall_pc", if_pc, held_pc);
      check("stall_instr", if_instr, held_instr);
      check("stall_noreq", {31'b0, imem_req}, 32'd0);
    end
    if_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("if_pc", if_pc, e.pc);
      check("if_instr", if_instr, e.instr);
      check("pc_plus4", pc_plus4, e.pc + 32'd4);
    end
    @(negedge clk);
    if_ready = 1'b0;
  endtask

  fvec_t tbl[6];
  int prev_start;

  initial begin
    tbl[0] = '{addr: 32'h00, ack_lat: 0, rdy_lat: 0};
    tbl[1] = '{addr: 32'h04, ack_lat: 0, rdy_lat: 0};
    tbl[2] = '{addr: 32'h08, ack_lat: 0, rdy_lat: 0};
    tbl[3] = '{addr: 32'h0C, ack_lat: 2, rdy_lat: 0};
    tbl[4] = '{addr: 32'h10, ack_lat: 0, rdy_lat: 5};
    tbl[5] = '{addr: 32'h14, ack_lat: 3, rdy_lat: 2};

    repeat (3) @(negedge clk);
    reset_values();
    rst = 1'b0;

    // Straight-line fetches, including back-to-back 2-cycle cadence.
    prev_start = 0;
    for (int i = 0; i < 6; i++) begin
      fetch_one(tbl[i].addr, tbl[i].ack_lat, tbl[i].rdy_lat);
      if (i == 1 || i == 2) check("cadence", start_cyc - prev_start, 32'd2);
      prev_start = start_cyc;
    end

    // Redirect in REQ without ack: old address held through drain, data dropped.
    wait_req();
    check("pre_drain_addr", imem_addr, 32'h18);
    redirect = 1'b1; redirect_pc = 32'h00000013; imem_ack = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("drain_addr", imem_addr, 32'h18);
      check("drain_req", {31'b0, imem_req}, 32'd1);
      @(negedge clk);
    end
    check("drain_addr", imem_addr, 32'h18);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("drain_discard", {31'b0, if_valid}, 32'd0);
    fetch_one(32'h10, 0, 0);

    // Redirect in HOLD while accepted: instruction dropped, no pc+4.
    wait_req();
    check("hold_req_addr", imem_addr, 32'h14);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h14);
    @(negedge clk);
    imem_ack = 1'b0;
    check("hold_valid", {31'b0, if_valid}, 32'd1);
    if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    if_ready = 1'b0; redirect = 1'b0;
    check("hold_redir_valid", {31'b0, if_valid}, 32'd0);
    check("hold_redir_addr", imem_addr, 32'h40);

    // Redirect in REQ with ack: data dropped, target bits [1:0] cleared.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFF;
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b0;
    check("ackredir_valid", {31'b0, if_valid}, 32'd0);
    check("ackredir_addr", imem_addr, 32'hFFFFFFFC);

    // Wrap at the top of the address space.
    fetch_one(32'hFFFFFFFC, 0, 0);
    wait_req();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc_plus4", pc_plus4, 32'h0);

    // Redirects during DRAIN: the latest target wins.
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect = 1'b0;
    check("drain2_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    fetch_one(32'h200, 0, 0);

    // Asynchronous reset in the middle of DRAIN.
    wait_req();
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    check("pre_rst_req", {31'b0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1 reset_values();
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'b0, if_valid}, 32'd0);
    imem_ack = 1'b0;
    fetch_one(32'h0, 0, 0);

    // Redirect while in IDLE.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h52;
    @(negedge clk);
    redirect = 1'b0;
    fetch_one(32'h50, 1, 1);

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
